// File: rtl/syscall_unit_if.sv
// Request/console bundle between Decode-stage hazard logic, the syscall unit and the console sink.
// The unit itself connects through the slave modport.
interface syscall_unit_if;
  logic        syscall_valid;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        syscall_busy;
  logic        halted;
  logic        sys_err;

  modport master (
    output syscall_valid, v0, a0, out_ready,
    input  out_valid, out_data, syscall_busy, halted, sys_err
  );

  modport slave (
    input  syscall_valid, v0, a0, out_ready,
    output out_valid, out_data, syscall_busy, halted, sys_err
  );
endinterface

// File: rtl/syscall_unit.sv
// MIPS syscall executor: print signed integer (double-dabble to decimal), print char and exit.
// Bytes leave through a registered ready/valid port; busy stalls younger instructions.
module syscall_unit #(
  parameter int DIGITS = 10
) (
  input  logic clk,
  input  logic rst_b,
  syscall_unit_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    EMIT,
    CHAR,
    HALT,
    ERR
  } state_t;

  state_t state, state_nxt;

  logic             sign;
  logic             sign_sent;
  logic             nz_seen;
  logic             last_loaded;
  logic [31:0]      mag;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [4:0]       cnt;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       char_byte;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             err_q;

  logic       xfer;
  logic       out_free;
  logic [3:0] cur_digit;
  logic       act_minus;
  logic       act_skip;
  logic       act_digit;
  logic       act_char;

  assign xfer      = out_valid_q && bus.out_ready;
  assign out_free  = !out_valid_q || xfer;
  assign cur_digit = bcd[{ptr, 2'b00} +: 4];

  // Double-dabble correction applied before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    act_minus = 1'b0;
    act_skip  = 1'b0;
    act_digit = 1'b0;
    act_char  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.syscall_valid) begin
          case (bus.v0)
            SVC_PRINT_INT:  state_nxt = CONV;
            SVC_PRINT_CHAR: state_nxt = CHAR;
            SVC_EXIT:       state_nxt = HALT;
            default:        state_nxt = ERR;
          endcase
        end
      end
      CONV: begin
        if (cnt == 5'd31) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        // Next byte is picked only once the output register is empty or draining this edge
        if (xfer && last_loaded) begin
          state_nxt = IDLE;
        end else if (out_free && !last_loaded) begin
          if (sign && !sign_sent) begin
            act_minus = 1'b1;
          end else if (cur_digit == 4'd0 && ptr != '0 && !nz_seen) begin
            act_skip = 1'b1;
          end else begin
            act_digit = 1'b1;
          end
        end
      end
      CHAR: begin
        if (xfer) begin
          state_nxt = IDLE;
        end else if (!out_valid_q) begin
          act_char = 1'b1;
        end
      end
      HALT: state_nxt = HALT;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sign        <= 1'b0;
      sign_sent   <= 1'b0;
      nz_seen     <= 1'b0;
      last_loaded <= 1'b0;
      mag         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ptr         <= '0;
      char_byte   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state == IDLE && bus.syscall_valid) begin
        sign        <= bus.a0[31];
        mag         <= bus.a0[31] ? (~bus.a0 + 32'd1) : bus.a0;
        bcd         <= '0;
        cnt         <= '0;
        ptr         <= PTR_W'(DIGITS - 1);
        sign_sent   <= 1'b0;
        nz_seen     <= 1'b0;
        last_loaded <= 1'b0;
        char_byte   <= bus.a0[7:0];
      end

      if (state == CONV) begin
        {bcd, mag} <= {bcd_adj, mag} << 1;
        cnt        <= cnt + 5'd1;
      end

      if (state == ERR) begin
        err_q <= 1'b1;
      end

      if (act_minus) begin
        out_valid_q <= 1'b1;
        out_data_q  <= 8'h2D;
        sign_sent   <= 1'b1;
      end else if (act_digit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= {4'h3, cur_digit};
        nz_seen     <= 1'b1;
        if (ptr == '0) begin
          last_loaded <= 1'b1;
        end else begin
          ptr <= ptr - 1'b1;
        end
      end else if (act_char) begin
        out_valid_q <= 1'b1;
        out_data_q  <= char_byte;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end

      if (act_skip) begin
        ptr <= ptr - 1'b1;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.syscall_busy = (state != IDLE);
  assign bus.halted       = (state == HALT);
  assign bus.sys_err      = err_q;
endmodule

// File: tb/tb_syscall_unit.sv
// Randomized self-checking bench for syscall_unit; expected byte streams come from
// decimal formatting of the argument, timing from digit counts.
module tb_syscall_unit;
  logic clk = 1'b0;
  logic rst_b;

  always #5 clk = ~clk;

  syscall_unit_if bus();

  syscall_unit #(.DIGITS(10)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic err_model = 1'b0;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end else begin
      passed++;
    end
  endtask

  function automatic logic pickReady(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2 == 0);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // Reference: what a console would show for printf("%d", (int)arg)
  task automatic buildInt(input logic [31:0] arg, output int nd);
    longint m;
    string  s;
    m = longint'($signed(arg));
    if (m < 0) begin
      exp_q.push_back(8'h2D);
      m = -m;
    end
    s = $sformatf("%0d", m);
    nd = s.len();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(byte'(s[i]));
  endtask

  task automatic applyStimulus(input logic [31:0] code, input logic [31:0] arg, input int mode, input string tag);
    int   nd, busy_cycles, first_valid, exp_first, exp_busy, n;
    bit   waiting, done;
    logic [7:0] held;
    got_q.delete();
    exp_q.delete();
    nd = 0;
    held = '0;
    if (code == 32'd1) buildInt(arg, nd);
    else if (code == 32'd11) exp_q.push_back(arg[7:0]);

    @(posedge clk); #1;
    bus.syscall_valid = 1'b1;
    bus.v0 = code;
    bus.a0 = arg;
    bus.out_ready = pickReady(mode, 0);
    @(posedge clk); #1;
    bus.syscall_valid = 1'b0;
    bus.v0 = $urandom;
    bus.a0 = $urandom;

    busy_cycles = 0;
    first_valid = -1;
    waiting = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (waiting) begin
        checkOutput({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({tag, " hold data"}, 64'(bus.out_data), 64'(held));
      end
      if (!bus.syscall_busy) begin
        done = 1'b1;
        break;
      end
      busy_cycles++;
      if (bus.out_valid && first_valid < 0) first_valid = k;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      waiting = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      @(posedge clk); #1;
      bus.out_ready = pickReady(mode, k + 1);
    end
    bus.out_ready = 1'b1;

    checkOutput({tag, " finished"}, 64'(done), 64'd1);
    checkOutput({tag, " byte count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, $sformatf(" byte%0d", i)}, 64'(got_q[i]), 64'(exp_q[i]));
    end

    if (code != 32'd1 && code != 32'd11) begin
      err_model = 1'b1;
      checkOutput({tag, " err busy"}, 64'(busy_cycles), 64'd1);
    end else if (mode == 0) begin
      if (code == 32'd11) begin
        exp_first = 1;
        exp_busy  = 2;
      end else begin
        exp_first = 33 + (arg[31] ? 0 : 10 - nd);
        exp_busy  = 43 + int'(arg[31]);
      end
      checkOutput({tag, " first valid"}, 64'(first_valid), 64'(exp_first));
      checkOutput({tag, " busy cycles"}, 64'(busy_cycles), 64'(exp_busy));
    end
    checkOutput({tag, " sys_err"}, 64'(bus.sys_err), 64'(err_model));
    checkOutput({tag, " halted"}, 64'(bus.halted), 64'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, " out_data"}, 64'(bus.out_data), 64'd0);
    checkOutput({tag, " busy"}, 64'(bus.syscall_busy), 64'd0);
    checkOutput({tag, " halted"}, 64'(bus.halted), 64'd0);
    checkOutput({tag, " sys_err"}, 64'(bus.sys_err), 64'd0);
  endtask

  task automatic runResetMidConv();
    int seen;
    @(posedge clk); #1;
    bus.syscall_valid = 1'b1;
    bus.v0 = 32'd1;
    bus.a0 = 32'd12345;
    @(posedge clk); #1;
    bus.syscall_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_b = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    err_model = 1'b0;
    checkIdleOutputs("reset mid conv");
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.out_valid || bus.syscall_busy) seen++;
    end
    checkOutput("after reset quiet", 64'(seen), 64'd0);
  endtask

  task automatic runResetCoincident();
    @(posedge clk); #1;
    rst_b = 1'b0;
    bus.syscall_valid = 1'b1;
    bus.v0 = 32'd11;
    bus.a0 = 32'h5A;
    @(posedge clk); #1;
    rst_b = 1'b1;
    bus.syscall_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset beats accept busy", 64'(bus.syscall_busy), 64'd0);
    checkOutput("reset beats accept valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic runExit();
    int held_cycles, ov_seen;
    @(posedge clk); #1;
    bus.syscall_valid = 1'b1;
    bus.v0 = 32'd10;
    bus.a0 = $urandom;
    @(posedge clk); #1;
    bus.syscall_valid = 1'b0;
    held_cycles = 0;
    ov_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.halted && bus.syscall_busy) held_cycles++;
      if (bus.out_valid) ov_seen++;
      @(posedge clk); #1;
      bus.syscall_valid = (k % 7 == 3);
      bus.v0 = 32'd11;
      bus.a0 = $urandom;
    end
    checkOutput("exit held", 64'(held_cycles), 64'd100);
    checkOutput("exit no output", 64'(ov_seen), 64'd0);
    bus.syscall_valid = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    err_model = 1'b0;
    checkIdleOutputs("exit cleared");
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] code, arg;
    logic [31:0] bad_codes [8];
    bad_codes = '{32'd0, 32'd2, 32'd3, 32'd5, 32'd7, 32'd9, 32'd12, 32'hFFFF_FFFF};

    bus.syscall_valid = 1'b0;
    bus.v0 = '0;
    bus.a0 = '0;
    bus.out_ready = 1'b1;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1 rst_b = 1'b1;

    applyStimulus(32'd11, 32'h41, 0, "char A");
    applyStimulus(32'd1, 32'hFFFF_FECF, 0, "int -305");
    applyStimulus(32'd1, 32'd0, 0, "int 0");
    applyStimulus(32'd1, 32'h8000_0000, 0, "int min");
    applyStimulus(32'd1, 32'hFFFF_FFFF, 0, "int -1");
    applyStimulus(32'd1, 32'd2147483647, 0, "int max");
    applyStimulus(32'd1, 32'd12, 1, "int 12 toggle");
    applyStimulus(32'd7, 32'd99, 0, "unknown 7");
    runResetMidConv();
    runResetCoincident();

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: code = 32'd1;
        5, 6, 7:       code = 32'd11;
        default:       code = bad_codes[$urandom_range(0, 7)];
      endcase
      case ($urandom_range(0, 5))
        0:       arg = 32'd0;
        1:       arg = 32'h8000_0000;
        2:       arg = 32'($urandom_range(0, 999));
        3:       arg = -32'($urandom_range(1, 999));
        default: arg = $urandom;
      endcase
      applyStimulus(code, arg, int'($urandom_range(0, 2)), $sformatf("rand%0d", t));
    end

    runExit();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/syscall_unit.md
# syscall_unit

Executes MIPS `syscall` instructions once the hazard unit has let them reach a clean Decode slot with `$v0`/`$a0` settled. It latches the service code and argument, and performs print-integer (signed decimal), print-char and exit. Characters go out on a ready/valid byte stream to the console model. While a service is in progress it raises a stall request back to the hazard logic so no younger instruction advances.

## Interface
Parameters:
- `DIGITS`, 10: decimal digit capacity. 10 covers 32-bit magnitudes.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge
- `rst_b`  input  1  synchronous, active-low reset, sampled on rising edge of `clk`
- `syscall_valid`  input  1  syscall in Decode, not stalled by hazard logic (accept request)
- `v0`  input  32  service code (register file `$v0` read in Decode)
- `a0`  input  32  argument (register file `$a0` read in Decode)
- `out_ready`  input  1  console sink can accept a byte
- `out_valid`  output  1  `out_data` holds a byte to transfer
- `out_data`  output  8  ASCII byte
- `syscall_busy`  output  1  stall request to hazard logic; high whenever state ≠ IDLE
- `halted`  output  1  exit service executed; sticky until reset
- `sys_err`  output  1  unknown service code seen; sticky until reset

## Operation
- States: IDLE, CONV, EMIT, CHAR, HALT.
- **Accept**: in IDLE with `syscall_valid`=1, latch `v0` and `a0`. `syscall_valid` outside IDLE is ignored.
- **Service `v0`=1 (print int)**:
  - Latch sign = `a0[31]`, mag = |`a0`| as 32-bit unsigned. 0x80000000 gives magnitude 2147483648.
  - Go to CONV.
- **CONV**:
  - Double-dabble over exactly 32 cycles.
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {BCD[39:0], mag} left by 1.
  - After the 32nd cycle, go to EMIT with digit pointer = 9 (most significant).
- **EMIT**:
  - If sign is set and not yet sent, present '-' (0x2D) first.
  - Then, while the pointer digit is 0, pointer > 0 and no nonzero digit has been emitted, skip one digit per cycle with `out_valid`=0.
  - Present each remaining digit as 0x30+d.
  - Digit 0 is always emitted, so zero prints "0".
  - After digit 0 transfers, go to IDLE.
- **Service `v0`=11 (print char)**: go to CHAR, present `a0[7:0]`, then return to IDLE after transfer.
- **Service `v0`=10 (exit)**: go to HALT. `halted`=1 and `syscall_busy`=1 until reset. No output.
- **Any other code**: set `sys_err`, stay busy one cycle, return to IDLE.
- **Handshake**:
  - A byte transfers on a rising edge with `out_valid`&&`out_ready`.
  - Once raised, `out_valid` stays high and `out_data` stays stable until transfer.
  - `out_ready` low stalls indefinitely; there is no timeout.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `syscall_busy`=0, `halted`=0, `sys_err`=0, state IDLE, latches cleared.
- Accept at edge E. `syscall_busy` rises at E (registered state ≠ IDLE) and falls on the edge after the final transfer or error cycle.
- Print int:
  - CONV occupies cycles E..E+31.
  - First `out_valid` in the cycle after E+32, or later by one cycle per skipped leading zero when no '-' is pending.
  - With `out_ready` tied high, one byte per cycle.
- Print char: `out_valid` asserted in the cycle right after E.
- Unknown code: `syscall_busy` high for exactly one cycle. `sys_err` rises at E+1.
- Reset mid-service (CONV/EMIT/CHAR/HALT): next edge returns to IDLE with all outputs at reset values. No partial byte is presented after reset.
- `syscall_valid` coincident with reset: reset wins, no accept.

## Test plan
- Reset, `v0`=11, `a0`=0x41, `out_ready`=1 → one byte 0x41 on the cycle after accept; busy high for 2 cycles; back to IDLE.
- `v0`=1, `a0`=-305 (0xFFFFFECF), `out_ready`=1 → bytes 0x2D,0x33,0x30,0x35 in order; busy drops after the '5' transfer.
- `v0`=1, `a0`=0 → single byte 0x30. `a0`=0x80000000 → "-2147483648" (11 bytes). `a0`=4294967295 is interpreted as -1 → "-1".
- `v0`=1, `a0`=12, `out_ready` toggled 1/0 every cycle → `out_data` stable while `out_valid`&&!`out_ready`; exactly bytes "12" delivered, no duplicates or drops.
- `v0`=10 → `halted`=1 and `syscall_busy`=1 persist 100 cycles; further `syscall_valid` pulses have no effect; `rst_b`=0 for one edge clears both.
- `v0`=7 → `sys_err`=1, no output, busy for 1 cycle. Then `v0`=1 with `rst_b` asserted during CONV → no bytes emitted; idle outputs on the next edge.
